sobel_window_gen: RTL and testbench



---
 rtl/sobel_pkg.sv | 12 +
 rtl/sobel_line_buffer.sv | 26 ++
 rtl/sobel_window_gen.sv | 120 ++++++++++++
 tb/tb_sobel_window_gen.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared types for the sobel window interface (window generator and sobel core wrapper).
package sobel_pkg;

  localparam int unsigned PIX_W = 8;

  typedef logic [PIX_W-1:0] pixel_t;

  // win[r][c], r,c in 1..3: row 1 = top/oldest line, col 1 = left/oldest column.
  // Element win[r][c] feeds sobel input s<r><c>.
  typedef pixel_t [1:3][1:3] win_t;

endpackage

// File: rtl/sobel_line_buffer.sv
// One line of pixel storage: synchronous write, combinational read of the
// currently stored (old) word so a read-modify-write fits in one cycle.
// Ports: clk; en (write enable); addr (column); wdata (word to store);
//        rdata (word at addr before this cycle's write).
module sobel_line_buffer #(
  parameter  int unsigned DEPTH = 352,
  parameter  int unsigned W     = 8,
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          en,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // Contents are never reset; rows are rewritten before any window uses them.
  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (en) mem[addr] <= wdata;
  end

endmodule

// File: rtl/sobel_window_gen.sv
// Streaming 3x3 window generator for the sobel core.
// Ports: clk, rst_n (async active-low);
//        pix_in/pix_valid/pix_sof/pix_ready : raster-order pixel input;
//        win/win_valid/win_last/win_ready   : registered 3x3 window output,
//        win_last marks the final window of a frame.
module sobel_window_gen
  import sobel_pkg::*;
#(
  parameter int unsigned IMG_W = 352,
  parameter int unsigned IMG_H = 288,
  parameter int unsigned PIX_W = sobel_pkg::PIX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_valid,
  input  logic             pix_sof,
  output logic             pix_ready,
  output win_t             win,
  output logic             win_valid,
  output logic             win_last,
  input  logic             win_ready
);

  localparam int unsigned COL_W = $clog2(IMG_W);
  localparam int unsigned ROW_W = $clog2(IMG_H);

  logic [ROW_W-1:0] row_q, row_d, cur_row;
  logic [COL_W-1:0] col_q, col_d, cur_col;
  win_t             sh_q, sh_d, win_d;
  logic             win_valid_d, win_last_d;
  logic             accept;
  pixel_t           pix, lb0_rd, lb1_rd;

  // Single output register: accept input only if the window slot frees this cycle.
  assign pix_ready = !win_valid || win_ready;
  assign accept    = pix_valid && pix_ready;
  assign pix       = pixel_t'(pix_in);

  // SOF forces the accepted pixel to (0,0) whatever the counters say.
  assign cur_row = pix_sof ? '0 : row_q;
  assign cur_col = pix_sof ? '0 : col_q;

  // lb0 holds line row-1, lb1 holds line row-2; lb0's old word shifts into lb1.
  sobel_line_buffer #(.DEPTH(IMG_W), .W($bits(pixel_t))) u_lb0 (
    .clk   (clk),
    .en    (accept),
    .addr  (cur_col),
    .wdata (pix),
    .rdata (lb0_rd)
  );

  sobel_line_buffer #(.DEPTH(IMG_W), .W($bits(pixel_t))) u_lb1 (
    .clk   (clk),
    .en    (accept),
    .addr  (cur_col),
    .wdata (lb0_rd),
    .rdata (lb1_rd)
  );

  // Next state: counters, shift window and output register.
  always_comb begin
    row_d       = row_q;
    col_d       = col_q;
    sh_d        = sh_q;
    win_d       = win;
    win_valid_d = win_valid;
    win_last_d  = win_last;

    if (win_valid && win_ready) begin
      win_valid_d = 1'b0;
      win_last_d  = 1'b0;
    end

    if (accept) begin
      for (int r = 1; r <= 3; r++) begin
        sh_d[r][1] = sh_q[r][2];
        sh_d[r][2] = sh_q[r][3];
      end
      sh_d[1][3] = lb1_rd;
      sh_d[2][3] = lb0_rd;
      sh_d[3][3] = pix;

      if (cur_col == COL_W'(IMG_W - 1)) begin
        col_d = '0;
        row_d = (cur_row == ROW_W'(IMG_H - 1)) ? '0 : cur_row + ROW_W'(1);
      end else begin
        col_d = cur_col + COL_W'(1);
        row_d = cur_row;
      end

      // Only interior-centred windows are emitted; a load beats a same-cycle drain.
      if (cur_row >= ROW_W'(2) && cur_col >= COL_W'(2)) begin
        win_d       = sh_d;
        win_valid_d = 1'b1;
        win_last_d  = (cur_row == ROW_W'(IMG_H - 1)) && (cur_col == COL_W'(IMG_W - 1));
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q     <= '0;
      col_q     <= '0;
      sh_q      <= '0;
      win       <= '0;
      win_valid <= 1'b0;
      win_last  <= 1'b0;
    end else begin
      row_q     <= row_d;
      col_q     <= col_d;
      sh_q      <= sh_d;
      win       <= win_d;
      win_valid <= win_valid_d;
      win_last  <= win_last_d;
    end
  end

endmodule

// File: tb/tb_sobel_window_gen.sv
// Scoreboard bench for sobel_window_gen on a 5x4 image.
module tb_sobel_window_gen;
  import sobel_pkg::*;

  localparam int W = 5;
  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] pix_in = '0;
  logic       pix_valid = 1'b0;
  logic       pix_sof = 1'b0;
  logic       pix_ready;
  win_t       win;
  logic       win_valid;
  logic       win_last;
  logic       win_ready = 1'b0;

  always #5 clk = ~clk;

  sobel_window_gen #(.IMG_W(W), .IMG_H(H), .PIX_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pix_in    (pix_in),
    .pix_valid (pix_valid),
    .pix_sof   (pix_sof),
    .pix_ready (pix_ready),
    .win       (win),
    .win_valid (win_valid),
    .win_last  (win_last),
    .win_ready (win_ready)
  );

  typedef struct packed {
    win_t w;
    logic last;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   n_win = 0;
  int   n_last = 0;
  win_t last_win;
  int   img [H][W];
  int   mr = 0;
  int   mc = 0;

  function automatic void check_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endfunction

  function automatic void check_win(input string name, input win_t act, input win_t req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endfunction

  // Reference model: image stored by raster position; a window is the 3x3 block ending at it.
  function automatic void model_accept(input logic [7:0] p, input logic sof);
    exp_t e;
    if (sof) begin
      mr = 0;
      mc = 0;
    end
    img[mr][mc] = int'(p);
    if (mr >= 2 && mc >= 2) begin
      for (int r = 1; r <= 3; r++)
        for (int c = 1; c <= 3; c++)
          e.w[r][c] = 8'(img[mr - 3 + r][mc - 3 + c]);
      e.last = (mr == H - 1) && (mc == W - 1);
      exp_q.push_back(e);
    end
    mc++;
    if (mc == W) begin
      mc = 0;
      mr = (mr == H - 1) ? 0 : mr + 1;
    end
  endfunction

  function automatic win_t ramp_win(input int r0, input int c0, input int off);
    win_t w;
    for (int r = 1; r <= 3; r++)
      for (int c = 1; c <= 3; c++)
        w[r][c] = 8'(10 * (r0 + r - 1) + (c0 + c - 1) + off);
    return w;
  endfunction

  task automatic cycle(input logic v, input logic [7:0] p, input logic sof,
                       input logic wr, output logic acc);
    @(negedge clk);
    pix_valid = v;
    pix_in    = p;
    pix_sof   = sof;
    win_ready = wr;
    #1;
    acc = v && pix_ready;
    if (acc) model_accept(p, sof);
  endtask

  task automatic send(input logic [7:0] p, input logic sof, input logic wr);
    logic acc;
    int   tries;
    acc   = 1'b0;
    tries = 0;
    while (!acc) begin
      cycle(1'b1, p, sof, wr, acc);
      tries++;
      if (!acc && tries > 200) begin
        check_int("send_timeout", 0, 1);
        break;
      end
    end
  endtask

  task automatic drain();
    logic acc;
    int   n;
    n = 0;
    while ((exp_q.size() != 0 || win_valid) && n < 200) begin
      cycle(1'b0, 8'h00, 1'b0, 1'b1, acc);
      n++;
    end
    cycle(1'b0, 8'h00, 1'b0, 1'b1, acc);
    check_int("drain_queue_empty", exp_q.size(), 0);
  endtask

  task automatic send_ramp_frame(input int off, input logic sof0);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        send(8'(10 * r + c + off), sof0 && r == 0 && c == 0, 1'b1);
  endtask

  // Monitor: pops on each output transfer and checks stability while stalled.
  initial begin : monitor
    logic hold;
    win_t hold_w;
    logic hold_l;
    exp_t e;
    hold = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          check_int("stall_valid", int'(win_valid), 1);
          check_win("stall_win", win, hold_w);
          check_int("stall_last", int'(win_last), int'(hold_l));
        end
        hold = 1'b0;
        if (win_valid && win_ready) begin
          if (exp_q.size() == 0) begin
            check_int("unexpected_window", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check_win("window", win, e.w);
            check_int("window_last", int'(win_last), int'(e.last));
            n_win++;
            if (win_last) n_last++;
            last_win = win;
          end
        end else if (win_valid) begin
          hold   = 1'b1;
          hold_w = win;
          hold_l = win_last;
        end
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic acc;
    int   idx;

    // Reset values.
    repeat (3) @(negedge clk);
    #1;
    check_int("rst_win_valid", int'(win_valid), 0);
    check_int("rst_win_last", int'(win_last), 0);
    check_win("rst_win", win, '0);
    check_int("rst_pix_ready", int'(pix_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Single frame, no sof, always ready.
    n_win = 0; n_last = 0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        send(8'(10 * r + c), 1'b0, 1'b1);
        if (r == 2 && c == 2) begin
          @(posedge clk);
          #1;
          check_int("first_win_valid", int'(win_valid), 1);
          check_win("first_win", win, ramp_win(0, 0, 0));
        end
      end
    drain();
    check_int("f1_windows", n_win, (W - 2) * (H - 2));
    check_int("f1_lasts", n_last, 1);
    check_int("f1_last_centre", int'(last_win[2][2]), 10 * (H - 2) + (W - 2));

    // Output stall after the first window.
    n_win = 0; n_last = 0;
    idx = 0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        if (idx == 13) begin
          for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 8'(10 * r + c), 1'b0, 1'b0, acc);
            check_int("stall_pix_ready", int'(pix_ready), 0);
          end
        end
        send(8'(10 * r + c), idx == 0, 1'b1);
        idx++;
      end
    drain();
    check_int("stall_windows", n_win, (W - 2) * (H - 2));
    check_int("stall_lasts", n_last, 1);

    // Back-to-back frames.
    n_win = 0; n_last = 0;
    send_ramp_frame(0, 1'b1);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        send(8'(10 * r + c + 100), 1'b0, 1'b1);
        if (r == 2 && c == 2) begin
          @(posedge clk);
          #1;
          check_win("f2_first_win", win, ramp_win(0, 0, 100));
        end
      end
    drain();
    check_int("b2b_windows", n_win, 2 * (W - 2) * (H - 2));
    check_int("b2b_lasts", n_last, 2);

    // SOF restart at pixel 7.
    n_win = 0; n_last = 0;
    for (int i = 0; i < 7; i++) send(8'(50 + i), 1'b0, 1'b1);
    for (int i = 0; i < W * H; i++) send(8'(10 * (i / W) + (i % W)), i == 0, 1'b1);
    drain();
    check_int("sof_windows", n_win, (W - 2) * (H - 2));
    check_int("sof_lasts", n_last, 1);

    // Reset mid-line 2 with a window pending.
    for (int i = 0; i < 13; i++) send(8'(10 * (i / W) + (i % W) + 30), 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, acc);
    @(negedge clk);
    rst_n = 1'b0;
    pix_valid = 1'b0;
    win_ready = 1'b0;
    exp_q.delete();
    mr = 0; mc = 0;
    #1;
    check_int("mid_rst_valid", int'(win_valid), 0);
    check_int("mid_rst_last", int'(win_last), 0);
    check_int("mid_rst_ready", int'(pix_ready), 1);
    @(negedge clk);
    #1;
    check_int("mid_rst_valid2", int'(win_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_int("post_rst_ready", int'(pix_ready), 1);
    check_int("post_rst_valid", int'(win_valid), 0);
    n_win = 0; n_last = 0;
    send_ramp_frame(200, 1'b0);
    drain();
    check_int("post_rst_windows", n_win, (W - 2) * (H - 2));
    check_int("post_rst_lasts", n_last, 1);

    // Random handshakes over three frames.
    n_win = 0; n_last = 0;
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < W * H; i++) begin
        logic [7:0] p;
        int tries;
        p = 8'($urandom);
        acc = 1'b0;
        tries = 0;
        while (!acc && tries < 500) begin
          cycle($urandom_range(0, 3) != 0, p, i == 0, 1'($urandom_range(0, 1)), acc);
          tries++;
        end
        if (!acc) check_int("rand_timeout", 0, 1);
      end
    drain();
    check_int("rand_windows", n_win, 3 * (W - 2) * (H - 2));
    check_int("rand_lasts", n_last, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
